// File: rtl/imem_responder_pkg.sv
// Shared constants for the instruction-memory responder: FSM encoding,
// SRAM data width, default wait states and wait-counter width.
package imem_responder_pkg;

    localparam int DATA_W          = 32;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int CNT_W           = 4;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/imem_wait_counter.sv
// Wait-state down-counter: load has priority over decrement, and zero
// flags the final wait cycle of an SRAM access.
import imem_responder_pkg::*;

module imem_wait_counter (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/imem_responder.sv
// Single-word instruction buffer in front of an asynchronous SRAM: hits are
// answered combinationally, misses run a fixed-length SRAM read then refill.
import imem_responder_pkg::*;

module imem_responder #(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int SRAM_AW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        fetch_addr,
    output logic [31:0]        fetch_data,
    output logic               fetch_stall,
    output logic               fetch_err,
    input  logic               flush,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    input  logic [31:0]        sram_data,
    output logic               dbg_state
);

    logic [0:0]        state_q, state_d;
    logic [29:0]       req_tag_q, req_tag_d;
    logic [29:0]       buf_tag_q, buf_tag_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic              buf_valid_q, buf_valid_d;

    logic hit;
    logic out_of_range;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^fetch_addr[1:0];

    // Full-tag compare means a word filled for an abandoned branch target
    // can never be mistaken for the current fetch address.
    assign hit          = buf_valid_q && (fetch_addr[31:2] == buf_tag_q);
    assign out_of_range = |fetch_addr[31:SRAM_AW+2];

    assign fetch_stall = !hit && !out_of_range;
    assign fetch_err   = out_of_range;
    assign fetch_data  = out_of_range ? 32'h0 : buf_data_q;

    assign sram_ce_n = (state_q != ST_ACCESS);
    assign sram_oe_n = (state_q != ST_ACCESS);
    assign sram_we_n = 1'b1;
    assign sram_addr = (state_q == ST_ACCESS) ? req_tag_q[SRAM_AW-1:0] : '0;
    assign dbg_state = state_q[0];

    imem_wait_counter u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(WAIT_CYCLES - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        req_tag_d   = req_tag_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        buf_valid_d = buf_valid_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        if (state_q == ST_IDLE) begin
            if (flush) begin
                buf_valid_d = 1'b0;
            end else if (!hit && !out_of_range) begin
                state_d   = ST_ACCESS;
                req_tag_d = fetch_addr[31:2];
                cnt_load  = 1'b1;
            end
        end else begin
            // Flush beats a fill completing on the same edge.
            if (flush) begin
                state_d     = ST_IDLE;
                buf_valid_d = 1'b0;
            end else if (cnt_zero) begin
                state_d     = ST_IDLE;
                buf_tag_d   = req_tag_q;
                buf_data_d  = sram_data;
                buf_valid_d = 1'b1;
            end else begin
                cnt_dec = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_tag_q   <= '0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_tag_q   <= req_tag_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            buf_valid_q <= buf_valid_d;
        end
    end

endmodule
